// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding/hazard unit.
package fwd_pkg;

    localparam int FWD_REG_W    = 5;
    localparam int DEF_ZERO_REG = 31;
    localparam int FWD_RF       = 0;

    typedef struct packed {
        logic                 valid;
        logic                 regwrite;
        logic                 memread;
        logic [FWD_REG_W-1:0] rd;
    } fwd_entry_t;

endpackage

// File: rtl/src_match.sv
// One source operand against every tracked stage: youngest-producer select plus load-use hit.
module src_match
    import fwd_pkg::*;
#(
    parameter int REG_W    = FWD_REG_W,
    parameter int DEPTH    = 2,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int SEL_W    = $clog2(DEPTH+1)
) (
    input  logic [REG_W-1:0]            src_reg_i,
    input  logic                        src_used_i,
    input  logic [DEPTH-1:0]            wr_i,
    input  logic [DEPTH-1:0][REG_W-1:0] rd_i,
    input  logic                        ld1_i,
    output logic [SEL_W-1:0]            sel_o,
    output logic                        load_hit_o
);

    logic [DEPTH-1:0] hit;
    logic             src_live;

    assign src_live = src_used_i && (src_reg_i != REG_W'(ZERO_REG));

    always_comb begin
        hit = '0;
        for (int k = 0; k < DEPTH; k++)
            hit[k] = src_live && wr_i[k] && (rd_i[k] == src_reg_i);
    end

    // Scan oldest to youngest so the youngest matching stage is the one that sticks.
    always_comb begin
        sel_o = SEL_W'(FWD_RF);
        for (int k = DEPTH-1; k >= 0; k--)
            if (hit[k]) sel_o = SEL_W'(k+1);
    end

    assign load_hit_o = hit[0] && ld1_i;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding selects and load-use stall for NUM_SRC decode operands against DEPTH in-flight stages.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter  int REG_W    = FWD_REG_W,
    parameter  int NUM_SRC  = 3,
    parameter  int DEPTH    = 2,
    parameter  int ZERO_REG = DEF_ZERO_REG,
    localparam int SEL_W    = $clog2(DEPTH+1)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     adv_i,
    input  logic                     flush_i,
    input  logic                     id_valid_i,
    input  logic [REG_W-1:0]         id_rd_i,
    input  logic                     id_regwrite_i,
    input  logic                     id_memread_i,
    input  logic [NUM_SRC*REG_W-1:0] src_reg_i,
    input  logic [NUM_SRC-1:0]       src_used_i,
    output logic [NUM_SRC*SEL_W-1:0] fwd_sel_o,
    output logic                     stall_o
);

    fwd_entry_t [DEPTH-1:0] ent_q, ent_d;

    logic [DEPTH-1:0]            wr_vec;
    logic [DEPTH-1:0][REG_W-1:0] rd_vec;
    logic [NUM_SRC-1:0]          load_hit;
    logic [NUM_SRC*SEL_W-1:0]    sel_raw;
    logic                        stall_raw;
    logic                        unused_oldest_mr;

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            wr_vec[k] = ent_q[k].valid && ent_q[k].regwrite;
            rd_vec[k] = ent_q[k].rd;
        end
    end

    // The oldest load flag only ever shifts out.
    assign unused_oldest_mr = ent_q[DEPTH-1].memread;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        src_match #(
            .REG_W    (REG_W),
            .DEPTH    (DEPTH),
            .ZERO_REG (ZERO_REG),
            .SEL_W    (SEL_W)
        ) u_match (
            .src_reg_i  (src_reg_i[i*REG_W +: REG_W]),
            .src_used_i (src_used_i[i]),
            .wr_i       (wr_vec),
            .rd_i       (rd_vec),
            .ld1_i      (ent_q[0].memread),
            .sel_o      (sel_raw[i*SEL_W +: SEL_W]),
            .load_hit_o (load_hit[i])
        );
    end

    assign stall_raw = |load_hit;

    always_comb begin
        ent_d = ent_q;
        if (adv_i) begin
            for (int k = DEPTH-1; k >= 1; k--)
                ent_d[k] = ent_q[k-1];
            // A stalled or flushed decode slot enters as a bubble.
            ent_d[0].valid    = id_valid_i && !stall_raw && !flush_i;
            ent_d[0].regwrite = id_regwrite_i;
            ent_d[0].memread  = id_memread_i;
            ent_d[0].rd       = id_rd_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) ent_q <= '0;
        else         ent_q <= ent_d;
    end

    assign fwd_sel_o = reset_i ? '0 : sel_raw;
    assign stall_o   = !reset_i && stall_raw;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench: per-cycle model comparison plus literal expectations at key points.
module tb_fwd_hazard_unit;

    localparam int REG_W   = 5;
    localparam int NUM_SRC = 3;
    localparam int DEPTH   = 2;
    localparam int SEL_W   = 2;
    localparam int XZR     = 31;

    logic                     clk = 1'b0;
    logic                     reset, adv, flush;
    logic                     id_valid, id_regwrite, id_memread;
    logic [REG_W-1:0]         id_rd;
    logic [NUM_SRC*REG_W-1:0] src_reg;
    logic [NUM_SRC-1:0]       src_used;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel;
    logic                     stall;

    int checks   = 0;
    int failures = 0;

    // Model: register each live producer in stage k will write (-1 = none), and whether it is a load.
    int m_dst [1:DEPTH];
    bit m_ld  [1:DEPTH];

    always #5 clk = ~clk;

    fwd_hazard_unit #(.REG_W(REG_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .ZERO_REG(XZR)) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .adv_i         (adv),
        .flush_i       (flush),
        .id_valid_i    (id_valid),
        .id_rd_i       (id_rd),
        .id_regwrite_i (id_regwrite),
        .id_memread_i  (id_memread),
        .src_reg_i     (src_reg),
        .src_used_i    (src_used),
        .fwd_sel_o     (fwd_sel),
        .stall_o       (stall)
    );

    function automatic int src_of(int i);
        return int'(src_reg[i*REG_W +: REG_W]);
    endfunction

    function automatic int exp_sel(int i);
        if (reset || !src_used[i] || src_of(i) == XZR) return 0;
        for (int k = 1; k <= DEPTH; k++)
            if (m_dst[k] == src_of(i)) return k;
        return 0;
    endfunction

    function automatic bit exp_stall();
        for (int i = 0; i < NUM_SRC; i++)
            if (exp_sel(i) == 1 && m_ld[1]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    initial begin
        for (int k = 1; k <= DEPTH; k++) begin
            m_dst[k] = -1;
            m_ld[k]  = 1'b0;
        end
    end

    always @(posedge clk) begin
        bit st;
        st = exp_stall();
        if (reset) begin
            for (int k = 1; k <= DEPTH; k++) begin
                m_dst[k] = -1;
                m_ld[k]  = 1'b0;
            end
        end else if (adv) begin
            for (int k = DEPTH; k >= 2; k--) begin
                m_dst[k] = m_dst[k-1];
                m_ld[k]  = m_ld[k-1];
            end
            m_dst[1] = (id_valid && id_regwrite && !st && !flush) ? int'(id_rd) : -1;
            m_ld[1]  = id_memread;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NUM_SRC; i++)
            chk($sformatf("model_sel%0d", i), int'(fwd_sel[i*SEL_W +: SEL_W]), exp_sel(i));
        chk("model_stall", int'(stall), int'(exp_stall()));
    end

    task automatic idc(input bit v, input int rd, input bit rw, input bit mr);
        id_valid    = v;
        id_rd       = REG_W'(rd);
        id_regwrite = rw;
        id_memread  = mr;
    endtask

    task automatic srcs(input int s0, input int s1, input int s2, input logic [2:0] used);
        src_reg  = {REG_W'(s2), REG_W'(s1), REG_W'(s0)};
        src_used = used;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Check this cycle's outputs against literals, then advance one edge.
    task automatic lit(input string name, input int i, input int es, input int est);
        @(negedge clk);
        #1;
        chk({name, "_sel"},   int'(fwd_sel[i*SEL_W +: SEL_W]), es);
        chk({name, "_stall"}, int'(stall), est);
        nxt();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; adv = 1'b1; flush = 1'b0;
        idc(1, 3, 1, 0); srcs(3, 0, 0, 3'b001);
        lit("rst0", 0, 0, 0);
        lit("rst1", 0, 0, 0);
        reset = 1'b0;
        lit("first", 0, 0, 0);

        idc(1, 10, 1, 0); lit("ex_fwd", 0, 1, 0);
        idc(1, 11, 1, 0); lit("mem_fwd", 0, 2, 0);
        idc(1, 12, 1, 0); lit("aged_out", 0, 0, 0);

        idc(1, 5, 1, 0); srcs(0, 0, 0, 3'b000); nxt();
        idc(1, 5, 1, 0); nxt();
        idc(1, 6, 0, 0); srcs(0, 5, 0, 3'b010); lit("youngest", 1, 1, 0);

        idc(1, 7, 1, 1); srcs(0, 0, 0, 3'b000); nxt();
        idc(1, 8, 1, 0); srcs(7, 0, 0, 3'b001);
        lit("lu_stall", 0, 1, 1);
        lit("lu_after", 0, 2, 0);

        idc(1, 13, 1, 0); srcs(13, 0, 0, 3'b001); lit("self", 0, 0, 0);

        idc(1, 31, 1, 1); srcs(0, 0, 0, 3'b000); nxt();
        idc(1, 15, 1, 0); srcs(31, 31, 0, 3'b011);
        lit("xzr0", 0, 0, 0);
        lit("xzr1", 1, 0, 0);

        idc(1, 4, 0, 0); srcs(0, 0, 0, 3'b000); nxt();
        idc(1, 16, 1, 0); srcs(0, 0, 4, 3'b100); lit("no_rw", 2, 0, 0);

        idc(1, 9, 1, 0); srcs(0, 0, 0, 3'b000); nxt();
        adv = 1'b0;
        idc(1, 20, 1, 0); srcs(9, 0, 0, 3'b001);
        lit("frz0", 0, 1, 0);
        lit("frz1", 0, 1, 0);
        lit("frz2", 0, 1, 0);
        adv = 1'b1;
        lit("frz_rel", 0, 1, 0);
        lit("frz_aged", 0, 2, 0);

        idc(0, 0, 0, 0); srcs(0, 0, 0, 3'b000); nxt(); nxt();

        flush = 1'b1; idc(1, 9, 1, 0); nxt();
        flush = 1'b0;
        idc(1, 21, 1, 0); srcs(9, 0, 0, 3'b001);
        lit("flush0", 0, 0, 0);
        lit("flush1", 0, 0, 0);

        idc(1, 14, 1, 1); srcs(0, 0, 0, 3'b000); nxt();
        flush = 1'b1;
        idc(1, 22, 1, 0); srcs(14, 0, 0, 3'b001);
        lit("sf_stall", 0, 1, 1);
        flush = 1'b0;
        lit("sf_after", 0, 2, 0);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit for the pipelined LEGv8 datapath. It generalises the single-pair RN/RD equality compare with RegWrite qualify to NUM_SRC source operands checked against DEPTH in-flight destination stages.
- It keeps its own registered shift pipeline of destination tags, so it produces per-source forwarding selects and a load-use stall.
- It sits beside the decode stage and drives the operand muxes in EX.

Parameters:
- REG_W, 5, register-index width.
- NUM_SRC, 3, number of source operands checked (Rn, Rm, Rt-for-store).
- DEPTH, 2, number of tracked downstream stages (1 = EX/MEM, 2 = MEM/WB). Legal range 1..4.
- ZERO_REG, 31, register index hard-wired to zero (XZR). It never matches.
- SEL_W, $clog2(DEPTH+1), width of each forwarding select. Derived; do not override.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- adv  in  1  pipeline advance enable. 0 = global freeze, all state holds.
- flush  in  1  squash the instruction entering stage 1 (taken branch).
- id_valid  in  1  decode slot holds a real instruction.
- id_rd  in  REG_W  decode destination register.
- id_regwrite  in  1  decode instruction writes the register file.
- id_memread  in  1  decode instruction is a load.
- src_reg  in  NUM_SRC*REG_W  source indices of the instruction in decode. Packed; source i occupies bits [i*REG_W +: REG_W].
- src_used  in  NUM_SRC  per-source "operand actually read" bit.
- fwd_sel  out  NUM_SRC*SEL_W  per source: 0 = register file, k = forward from stage k.
- stall  out  1  load-use hazard. Freezes PC and IF/ID and forces a bubble.

Behaviour:
- Tracking state: DEPTH entries, each holding {valid, regwrite, memread, rd}. Entry 1 is the youngest.
- Reset (on a clk edge with reset=1): all entry fields are cleared to 0. While reset is high, fwd_sel = 0 and stall = 0 regardless of inputs.
- Shift rule, applied at a clk edge with adv=1:
  - entry[k] <= entry[k-1] for k = 2..DEPTH. The oldest entry is discarded.
  - entry[1] <= decode info, except entry[1].valid is forced to 0 when stall=1 or flush=1. This inserts a bubble.
- Freeze: adv=0 holds all entries unchanged. Outputs continue to be evaluated combinationally from the held state.
- Match for source i against stage k requires all of the following:
  - entry[k].valid and entry[k].regwrite are 1;
  - entry[k].rd == src_reg[i];
  - src_reg[i] != ZERO_REG;
  - src_used[i] = 1.
- fwd_sel[i]: the smallest matching k, so the youngest producer wins. 0 if no stage matches. Purely combinational from registered state plus current inputs, with zero-cycle latency.
- stall: 1 when any source matches stage 1 and entry[1].memread = 1 (load-use).
  - fwd_sel is still computed normally during a stall. The consumer ignores it until the load reaches stage 2.
  - After exactly one bubble, the same decode instruction sees the load in stage 2, so fwd_sel = 2 and stall = 0.
- Simultaneous stall and flush: flush wins for the entry written; stall still drives the output that cycle.
- Decode self-match: id_rd == src_reg of the same instruction is not a hazard. The decode entry is never compared against itself.
- DEPTH = 1: only stage 1 exists. Loads can then only stall. The table has no stage-2 forward.
- Arithmetic: equality compares are on exactly REG_W bits, with no sign or width extension.

Decomposition:
- Package fwd_pkg holds:
  - typedef fwd_entry_t (valid, regwrite, memread, rd[REG_W-1:0]);
  - localparam FWD_RF = 0 (register-file select);
  - default ZERO_REG = 31.
- One sub-module, src_match: one source against all DEPTH entries, producing a priority-encoded sel and a load-hit bit.
- Top level instantiates NUM_SRC copies of src_match via generate and ORs the load-hit bits into stall.

Test Plan:
- Reset held 2 cycles with id_valid = 1, id_rd = 3, id_regwrite = 1 → fwd_sel = 0 and stall = 0 throughout. After release, the first match appears only after an advancing edge.
- ADD X3 issued, next instruction reads Rn = 3 → fwd_sel[0] = 1. One cycle later, a reader of X3 sees fwd_sel = 2. Two cycles later, fwd_sel = 0.
- Back-to-back writers X5 (older) and X5 (younger), consumer reads Rm = 5 → fwd_sel[1] = 1 (youngest wins).
- LDUR X7 followed by ADD reading Rn = 7 → stall = 1 for exactly one cycle, then fwd_sel[0] = 2 and stall = 0.
- Writer with rd = 31 and consumer reading 31 → fwd_sel = 0 and no stall. Writer with rd = 4 but regwrite = 0 → no match.
- Two freeze/flush cases:
  - adv = 0 for 3 cycles with X9 in stage 1 → fwd_sel remains 1 for a reader of X9.
  - flush = 1 on the cycle X9 would enter → no later match on 9.
